cmd_frame_ctrl: RTL and testbench
=================================

Name: cmd_frame_ctrl

Overview:
- Framed command parser and configuration controller between the USB byte receiver and the signal generator.
- Accepts a byte stream (one byte per rx_valid pulse) and validates 5-byte frames by checksum.
- Valid frames write shadow registers for waveform, frequency, amplitude and phase.
- A commit opcode transfers all shadows to the live outputs in one cycle, so sig_gen never sees a partially updated configuration.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes inside a frame (10 ms at 100 MHz).
- DEF_STATE, 3'd0, reset/default waveform select.
- DEF_FREQ, 12'd100, reset/default frequency word.
- DEF_AMP, 3'd7, reset/default amplitude code.
- DEF_PHASE, 8'd0, reset/default phase offset.

Ports:
- clk  in  1  system clock, 100 MHz domain.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- state  out  3  live waveform select.
- state_freq  out  12  live frequency word.
- state_amp  out  3  live amplitude code.
- state_phase  out  8  live phase offset.
- cfg_update  out  1  one-cycle pulse when live outputs change (commit).
- err_cksum  out  1  one-cycle pulse on checksum mismatch.
- err_op  out  1  one-cycle pulse on a valid-checksum frame with an unknown opcode.
- err_timeout  out  1  one-cycle pulse on frame timeout.
- busy  out  1  high while the FSM is not in S_IDLE.

Behaviour:
- Reset: the following apply on any clk edge with rst=1, and rst overrides every other event in the same cycle.
  - Live outputs and all shadows take the DEF_* values.
  - FSM goes to S_IDLE.
  - Timeout counter clears.
  - All pulses and busy go to 0.
- Frame format: SYNC_BYTE, OP, D1, D0, CK, with CK = OP ^ D1 ^ D0.
- FSM states: S_IDLE -> S_OP -> S_D1 -> S_D0 -> S_CK. Each transition occurs only on rx_valid=1.
  - S_IDLE: a byte other than SYNC_BYTE is ignored and the FSM stays in S_IDLE. SYNC_BYTE moves to S_OP.
  - S_OP, S_D1, S_D0: latch the byte into the op, d1 or d0 register and advance.
  - Inside a frame, SYNC_BYTE is ordinary data; there is no mid-frame resynchronisation.
  - S_CK: compare the byte to op^d1^d0 and return to S_IDLE unconditionally.
- Checksum mismatch: err_cksum pulses on the cycle after the CK byte is accepted; shadows and outputs are unchanged.
- Checksum match, opcode action (all results are registered, visible the cycle after the CK byte):
  - 0x01: shadow_state <= D0[2:0].
  - 0x02: shadow_freq <= {D1[3:0], D0}; D1[7:4] are ignored.
  - 0x03: shadow_amp <= D0[2:0].
  - 0x04: shadow_phase <= D0.
  - 0x0E: all shadows <= DEF_*; outputs are unchanged.
  - 0x0F: live outputs <= shadows, and cfg_update pulses in the same cycle the outputs change. A commit with no prior writes still pulses.
  - Any other opcode: err_op pulses; no register changes.
- Latency: exactly 1 clk from the rx_valid cycle of the CK byte to the register/pulse effect.
- Timeout:
  - The counter clears on every accepted byte and counts while the FSM is not in S_IDLE and rx_valid=0.
  - When the counter reaches TIMEOUT_CYC-1 with rx_valid=0, err_timeout pulses, the FSM goes to S_IDLE and the partial frame is discarded.
  - If rx_valid=1 in that same cycle, the byte wins: it is accepted and no timeout occurs.
  - The counter is held at 0 in S_IDLE.
- Back-to-back: a SYNC_BYTE arriving in the cycle immediately after the CK byte is accepted normally. The parser never drops bytes, and rx_valid on consecutive cycles is legal.
- busy = (FSM != S_IDLE), registered with the FSM.
- Pulses are mutually exclusive per frame, and each is high for exactly one cycle.

Test Plan:
1. Reset, then observe -> state=0, state_freq=100, state_amp=7, state_phase=0; busy and all pulses = 0.
2. Frames A5 02 03 E8 E9, then A5 0F 00 00 0F -> state_freq stays 100 after the first frame; after the commit CK, one cycle later, state_freq=1000 and cfg_update=1 for one cycle.
3. Frame A5 04 00 80 85 (bad CK; correct is 84) -> err_cksum pulses; a following commit frame leaves state_phase=0.
4. Bytes 11 22 A5 03 then no rx_valid for TIMEOUT_CYC cycles -> the leading bytes are ignored; busy=1 after A5; err_timeout pulses once; busy=0; then a full A5 03 00 05 06 plus commit -> state_amp=5.
5. Frame A5 07 00 00 07 -> err_op pulse with no register change. Separately, rst asserted while in S_D1 -> S_IDLE and defaults restored on the next edge, with no pulses.
6. Two frames back-to-back with rx_valid on consecutive cycles (A5 01 00 03 02 A5 0F 00 00 0F) -> state=3 and one cfg_update, 1 clk after the final CK byte.

Source files
------------

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl
// Framed command parser and configuration controller. Sits between the USB
// byte receiver and the signal generator.
//
// A frame is five bytes: SYNC_BYTE, OP, D1, D0, CK, where CK = OP ^ D1 ^ D0.
// Frames with a good checksum write shadow registers. A commit opcode copies
// every shadow to the live outputs in a single cycle, so downstream logic
// never sees a half-updated configuration.
//
// Ports
//   clk          system clock (100 MHz domain)
//   rst          synchronous reset, active-high
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   state        live waveform select
//   state_freq   live frequency word
//   state_amp    live amplitude code
//   state_phase  live phase offset
//   cfg_update   one-cycle pulse when the live outputs are committed
//   err_cksum    one-cycle pulse on a checksum mismatch
//   err_op       one-cycle pulse on a good frame with an unknown opcode
//   err_timeout  one-cycle pulse when a partial frame is abandoned
//   busy         high while a frame is in progress
module cmd_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [2:0]  DEF_STATE   = 3'd0,
    parameter logic [11:0] DEF_FREQ    = 12'd100,
    parameter logic [2:0]  DEF_AMP     = 3'd7,
    parameter logic [7:0]  DEF_PHASE   = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [2:0]  state,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        cfg_update,
    output logic        err_cksum,
    output logic        err_op,
    output logic        err_timeout,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_D1   = 3'd2;
    localparam logic [2:0] S_D0   = 3'd3;
    localparam logic [2:0] S_CK   = 3'd4;

    localparam logic [7:0] OP_STATE  = 8'h01;
    localparam logic [7:0] OP_FREQ   = 8'h02;
    localparam logic [7:0] OP_AMP    = 8'h03;
    localparam logic [7:0] OP_PHASE  = 8'h04;
    localparam logic [7:0] OP_DEFLT  = 8'h0E;
    localparam logic [7:0] OP_COMMIT = 8'h0F;

    // The counter only ever needs to reach TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       fsm_reg;
    logic [7:0]       op_reg;
    logic [7:0]       d1_reg;
    logic [7:0]       d0_reg;
    logic [CNT_W-1:0] tmo_cnt_reg;

    logic [2:0]       shadow_state_reg;
    logic [11:0]      shadow_freq_reg;
    logic [2:0]       shadow_amp_reg;
    logic [7:0]       shadow_phase_reg;

    logic [2:0]       live_state_reg;
    logic [11:0]      live_freq_reg;
    logic [2:0]       live_amp_reg;
    logic [7:0]       live_phase_reg;

    logic             cfg_update_reg;
    logic             err_cksum_reg;
    logic             err_op_reg;
    logic             err_timeout_reg;

    logic [7:0]       cksum_calc;
    assign cksum_calc = op_reg ^ d1_reg ^ d0_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg          <= S_IDLE;
            op_reg           <= 8'h00;
            d1_reg           <= 8'h00;
            d0_reg           <= 8'h00;
            tmo_cnt_reg      <= '0;
            shadow_state_reg <= DEF_STATE;
            shadow_freq_reg  <= DEF_FREQ;
            shadow_amp_reg   <= DEF_AMP;
            shadow_phase_reg <= DEF_PHASE;
            live_state_reg   <= DEF_STATE;
            live_freq_reg    <= DEF_FREQ;
            live_amp_reg     <= DEF_AMP;
            live_phase_reg   <= DEF_PHASE;
            cfg_update_reg   <= 1'b0;
            err_cksum_reg    <= 1'b0;
            err_op_reg       <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            cfg_update_reg  <= 1'b0;
            err_cksum_reg   <= 1'b0;
            err_op_reg      <= 1'b0;
            err_timeout_reg <= 1'b0;

            if (rx_valid) begin
                // An accepted byte always wins over a timeout in the same cycle.
                tmo_cnt_reg <= '0;
                case (fsm_reg)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            fsm_reg <= S_OP;
                        end
                    end
                    S_OP: begin
                        op_reg  <= rx_data;
                        fsm_reg <= S_D1;
                    end
                    S_D1: begin
                        d1_reg  <= rx_data;
                        fsm_reg <= S_D0;
                    end
                    S_D0: begin
                        d0_reg  <= rx_data;
                        fsm_reg <= S_CK;
                    end
                    S_CK: begin
                        fsm_reg <= S_IDLE;
                        if (rx_data != cksum_calc) begin
                            err_cksum_reg <= 1'b1;
                        end else begin
                            case (op_reg)
                                OP_STATE: shadow_state_reg <= d0_reg[2:0];
                                OP_FREQ:  shadow_freq_reg  <= {d1_reg[3:0], d0_reg};
                                OP_AMP:   shadow_amp_reg   <= d0_reg[2:0];
                                OP_PHASE: shadow_phase_reg <= d0_reg;
                                OP_DEFLT: begin
                                    shadow_state_reg <= DEF_STATE;
                                    shadow_freq_reg  <= DEF_FREQ;
                                    shadow_amp_reg   <= DEF_AMP;
                                    shadow_phase_reg <= DEF_PHASE;
                                end
                                OP_COMMIT: begin
                                    live_state_reg <= shadow_state_reg;
                                    live_freq_reg  <= shadow_freq_reg;
                                    live_amp_reg   <= shadow_amp_reg;
                                    live_phase_reg <= shadow_phase_reg;
                                    cfg_update_reg <= 1'b1;
                                end
                                default:  err_op_reg <= 1'b1;
                            endcase
                        end
                    end
                    default: fsm_reg <= S_IDLE;
                endcase
            end else if (fsm_reg != S_IDLE) begin
                // Mid-frame silence: abandon the partial frame once the
                // counter has seen TIMEOUT_CYC idle cycles.
                if (tmo_cnt_reg == TMO_LAST) begin
                    err_timeout_reg <= 1'b1;
                    fsm_reg         <= S_IDLE;
                    tmo_cnt_reg     <= '0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign state       = live_state_reg;
    assign state_freq  = live_freq_reg;
    assign state_amp   = live_amp_reg;
    assign state_phase = live_phase_reg;
    assign cfg_update  = cfg_update_reg;
    assign err_cksum   = err_cksum_reg;
    assign err_op      = err_op_reg;
    assign err_timeout = err_timeout_reg;
    // fsm_reg is a register, so busy changes on the same edge as the FSM.
    assign busy        = (fsm_reg != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
module tb_cmd_frame_ctrl;

    localparam int T = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        cfg_update;
    logic        err_cksum;
    logic        err_op;
    logic        err_timeout;
    logic        busy;

    cmd_frame_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .cfg_update  (cfg_update),
        .err_cksum   (err_cksum),
        .err_op      (err_op),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the frame being collected is a queue of bytes,
    // silence is counted in whole idle cycles.
    byte unsigned frame_q[$];
    int idle_cycles;
    int sh_state, sh_freq, sh_amp, sh_phase;
    int lv_state, lv_freq, lv_amp, lv_phase;
    int ex_upd, ex_ck, ex_op, ex_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_defaults();
        sh_state = 0; sh_freq = 100; sh_amp = 7; sh_phase = 0;
        lv_state = 0; lv_freq = 100; lv_amp = 7; lv_phase = 0;
        frame_q.delete();
        idle_cycles = 0;
    endtask

    task automatic model_frame();
        byte unsigned op, d1, d0, ck;
        op = frame_q[1]; d1 = frame_q[2]; d0 = frame_q[3]; ck = frame_q[4];
        if (ck != (op ^ d1 ^ d0)) begin
            ex_ck = 1;
        end else if (op == 8'h01) sh_state = d0 % 8;
        else if (op == 8'h02) sh_freq = (d1 % 16) * 256 + d0;
        else if (op == 8'h03) sh_amp = d0 % 8;
        else if (op == 8'h04) sh_phase = d0;
        else if (op == 8'h0E) begin
            sh_state = 0; sh_freq = 100; sh_amp = 7; sh_phase = 0;
        end else if (op == 8'h0F) begin
            lv_state = sh_state; lv_freq = sh_freq; lv_amp = sh_amp; lv_phase = sh_phase;
            ex_upd = 1;
        end else ex_op = 1;
    endtask

    // One clock cycle: apply inputs, advance the model, compare every output.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input string tag);
        rst = r; rx_valid = v; rx_data = d;
        @(posedge clk);
        #1;
        ex_upd = 0; ex_ck = 0; ex_op = 0; ex_tmo = 0;
        if (r) begin
            model_defaults();
        end else if (v) begin
            idle_cycles = 0;
            if (frame_q.size() > 0 || d == SYNC) frame_q.push_back(d);
            if (frame_q.size() == 5) begin
                model_frame();
                frame_q.delete();
            end
        end else if (frame_q.size() > 0) begin
            idle_cycles++;
            if (idle_cycles == T) begin
                ex_tmo = 1;
                frame_q.delete();
                idle_cycles = 0;
            end
        end
        check({tag, ".state"}, 32'(state), 32'(lv_state));
        check({tag, ".freq"}, 32'(state_freq), 32'(lv_freq));
        check({tag, ".amp"}, 32'(state_amp), 32'(lv_amp));
        check({tag, ".phase"}, 32'(state_phase), 32'(lv_phase));
        check({tag, ".cfg_update"}, 32'(cfg_update), 32'(ex_upd));
        check({tag, ".err_cksum"}, 32'(err_cksum), 32'(ex_ck));
        check({tag, ".err_op"}, 32'(err_op), 32'(ex_op));
        check({tag, ".err_timeout"}, 32'(err_timeout), 32'(ex_tmo));
        check({tag, ".busy"}, 32'(busy), 32'(frame_q.size() > 0));
        $display("step %-10s rst=%0b v=%0b d=%02h -> st=%0d f=%0d a=%0d p=%0d upd=%0b ck=%0b op=%0b to=%0b busy=%0b",
                 tag, r, v, d, state, state_freq, state_amp, state_phase,
                 cfg_update, err_cksum, err_op, err_timeout, busy);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        step(1'b0, 1'b1, b, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, tag);
    endtask

    task automatic frame(input logic [7:0] op, input logic [7:0] d1, input logic [7:0] d0,
                         input logic corrupt, input string tag);
        logic [7:0] ck;
        ck = op ^ d1 ^ d0;
        if (corrupt) ck = ck ^ 8'h01;
        send(SYNC, tag); send(op, tag); send(d1, tag); send(d0, tag); send(ck, tag);
    endtask

    initial begin
        logic [7:0] ops [8];
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03; ops[3] = 8'h04;
        ops[4] = 8'h0E; ops[5] = 8'h0F; ops[6] = 8'h0F; ops[7] = 8'h00;
        model_defaults();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        #1;

        // 1. reset
        step(1'b1, 1'b0, 8'h00, "reset");
        step(1'b1, 1'b1, SYNC, "reset");
        idle(2, "post_rst");

        // 2. frequency write then commit
        frame(8'h02, 8'h03, 8'hE8, 1'b0, "freq_wr");
        check("freq_uncommitted", 32'(state_freq), 32'd100);
        frame(8'h0F, 8'h00, 8'h00, 1'b0, "commit1");
        check("freq_committed", 32'(state_freq), 32'd1000);
        check("commit1_pulse", 32'(cfg_update), 32'd1);
        idle(1, "gap");
        check("commit1_pulse_end", 32'(cfg_update), 32'd0);

        // 3. bad checksum
        send(SYNC, "bad_ck"); send(8'h04, "bad_ck"); send(8'h00, "bad_ck");
        send(8'h80, "bad_ck"); send(8'h85, "bad_ck");
        check("bad_ck_pulse", 32'(err_cksum), 32'd1);
        frame(8'h0F, 8'h00, 8'h00, 1'b0, "commit2");
        check("phase_kept", 32'(state_phase), 32'd0);

        // 4. leading junk, then timeout, then a good amplitude write
        send(8'h11, "junk"); send(8'h22, "junk");
        check("junk_not_busy", 32'(busy), 32'd0);
        send(SYNC, "tmo"); send(8'h03, "tmo");
        check("busy_in_frame", 32'(busy), 32'd1);
        idle(T, "tmo_wait");
        check("tmo_pulse", 32'(err_timeout), 32'd1);
        idle(1, "tmo_after");
        frame(8'h03, 8'h00, 8'h05, 1'b0, "amp_wr");
        frame(8'h0F, 8'h00, 8'h00, 1'b0, "commit3");
        check("amp_committed", 32'(state_amp), 32'd5);

        // byte arriving on the last allowed idle cycle wins over the timeout
        send(SYNC, "edge"); send(8'h04, "edge");
        idle(T - 1, "edge_wait");
        send(8'h00, "edge"); send(8'h10, "edge"); send(8'h14, "edge");

        // 5. unknown opcode, then reset in the middle of a frame
        frame(8'h07, 8'h00, 8'h00, 1'b0, "bad_op");
        check("bad_op_pulse", 32'(err_op), 32'd1);
        send(SYNC, "mid_rst"); send(8'h01, "mid_rst");
        step(1'b1, 1'b0, 8'h00, "mid_rst");
        check("mid_rst_idle", 32'(busy), 32'd0);

        // 6. back-to-back frames
        frame(8'h01, 8'h00, 8'h03, 1'b0, "b2b");
        frame(8'h0F, 8'h00, 8'h00, 1'b0, "b2b");
        check("b2b_state", 32'(state), 32'd3);
        check("b2b_pulse", 32'(cfg_update), 32'd1);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int g;
            if ($urandom_range(7) == 0) send(8'($urandom), "rnd_junk");
            if ($urandom_range(39) == 0) step(1'b1, 1'b0, 8'h00, "rnd_rst");
            send(SYNC, "rnd");
            send(ops[$urandom_range(7)] | (($urandom_range(9) == 0) ? 8'h40 : 8'h00), "rnd");
            for (int k = 0; k < 3; k++) begin
                g = ($urandom_range(11) == 0) ? int'($urandom_range(T + 1, T - 1)) : int'($urandom_range(2));
                idle(g, "rnd_gap");
                send(8'($urandom), "rnd");
            end
        end
        // finish any open frame with a guaranteed timeout
        idle(T + 1, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
